// File: rtl/max7219_chain_tx.sv
// SPI transmitter for a daisy chain of MAX7219/7221 drivers: one frame shifts one
// word per device MSB first, then a common LOAD pulse latches every device at once.
module max7219_chain_tx #(
  parameter int WORD_WIDTH = 16,
  parameter int N_DEV      = 4,
  parameter int CLK_DIV    = 10,
  parameter int LOAD_HOLD  = 5
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [N_DEV*WORD_WIDTH-1:0] i_data,
  input  logic                        i_bcast,
  input  logic                        i_wr,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_spi_clk,
  output logic                        o_spi_data,
  output logic                        o_spi_load
);

  localparam int TOTAL  = N_DEV * WORD_WIDTH;
  localparam int BIT_W  = $clog2(TOTAL + 1);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HOLD_W = (LOAD_HOLD > 1) ? $clog2(LOAD_HOLD) : 1;

  localparam logic [DIV_W-1:0]  RISE_AT    = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0]  FALL_AT    = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BITS_FULL  = BIT_W'(TOTAL);
  localparam logic [BIT_W-1:0]  BITS_LAST  = BIT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_START = HOLD_W'(LOAD_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state, state_n;
  logic [TOTAL-1:0]   shreg, shreg_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [DIV_W-1:0]   div_cnt, div_cnt_n;
  logic [HOLD_W-1:0]  hold_cnt, hold_cnt_n;
  logic               sclk_n, sdata_n, done_n;
  logic               wr_req;
  logic [TOTAL-1:0]   load_word;

  assign wr_req    = i_wr && !o_busy;
  assign load_word = i_bcast ? {N_DEV{i_data[WORD_WIDTH-1:0]}} : i_data;

  // State and all registered outputs; reset forces LOAD high and SCLK low at once.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      o_busy     <= 1'b1;
      o_done     <= 1'b0;
      o_spi_clk  <= 1'b0;
      o_spi_data <= 1'b0;
      o_spi_load <= 1'b1;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      div_cnt    <= div_cnt_n;
      hold_cnt   <= hold_cnt_n;
      o_busy     <= (state_n != IDLE);
      o_done     <= done_n;
      o_spi_clk  <= sclk_n;
      o_spi_data <= sdata_n;
      o_spi_load <= (state_n != SHIFT);
    end
  end

  // Next-state logic: SCLK rises mid-period; data advances on each fall.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    div_cnt_n  = div_cnt;
    hold_cnt_n = hold_cnt;
    sclk_n     = 1'b0;
    sdata_n    = 1'b0;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req) begin
          state_n   = SHIFT;
          shreg_n   = load_word;
          bit_cnt_n = BITS_FULL;
          div_cnt_n = '0;
          sdata_n   = load_word[TOTAL-1];
        end else begin
          sdata_n = 1'b0;
        end
      end
      SHIFT: begin
        sdata_n = shreg[TOTAL-1];
        sclk_n  = o_spi_clk;
        if (div_cnt == RISE_AT) begin
          sclk_n    = 1'b1;
          div_cnt_n = div_cnt + DIV_W'(1);
        end else if (div_cnt == FALL_AT) begin
          sclk_n    = 1'b0;
          div_cnt_n = '0;
          if (bit_cnt == BITS_LAST) begin
            state_n    = HOLD;
            hold_cnt_n = HOLD_START;
            bit_cnt_n  = '0;
            sdata_n    = 1'b0;
          end else begin
            shreg_n   = {shreg[TOTAL-2:0], 1'b0};
            sdata_n   = shreg[TOTAL-2];
            bit_cnt_n = bit_cnt - BIT_W'(1);
          end
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          hold_cnt_n = hold_cnt - HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_max7219_chain_tx.sv
// Directed bench: a 2-device chain (CLK_DIV=4, LOAD_HOLD=3) and a 1-device
// corner instance (CLK_DIV=2, LOAD_HOLD=2), driven from one linear sequence.
module tb_max7219_chain_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_a;
  logic        bcast_a, wr_a;
  logic        busy_a, done_a, sclk_a, sdata_a, load_a;
  logic [15:0] data_b;
  logic        bcast_b, wr_b;
  logic        busy_b, done_b, sclk_b, sdata_b, load_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  max7219_chain_tx #(.WORD_WIDTH(16), .N_DEV(2), .CLK_DIV(4), .LOAD_HOLD(3)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data(data_a), .i_bcast(bcast_a), .i_wr(wr_a),
    .o_busy(busy_a), .o_done(done_a), .o_spi_clk(sclk_a), .o_spi_data(sdata_a),
    .o_spi_load(load_a)
  );

  max7219_chain_tx #(.WORD_WIDTH(16), .N_DEV(1), .CLK_DIV(2), .LOAD_HOLD(2)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data(data_b), .i_bcast(bcast_b), .i_wr(wr_b),
    .o_busy(busy_b), .o_done(done_b), .o_spi_clk(sclk_b), .o_spi_data(sdata_b),
    .o_spi_load(load_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on dut_a: waits for idle, writes, then samples ncyc cycles at negedge.
  // rst_at >= 0 pulses reset after that sample and checks the pins one cycle later.
  task automatic frame_a(input logic [31:0] d, input logic b, input int ncyc, input int rst_at,
                         output logic [31:0] bits, output int ld_low, output int rises,
                         output int busy_c, output int dones);
    int   guard;
    logic prev;
    guard = 0; bits = '0; ld_low = 0; rises = 0; busy_c = 1; dones = 0; prev = 1'b0;
    while (busy_a === 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    chk("a_idle_before_wr", {31'd0, busy_a}, 32'd0);
    wr_a = 1'b1; data_a = d; bcast_a = b;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      wr_a = 1'b0; data_a = $urandom; bcast_a = 1'($urandom_range(0, 1));
      rst = (i == rst_at) ? 1'b1 : 1'b0;
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("a_rst_load", {31'd0, load_a}, 32'd1);
        chk("a_rst_sclk", {31'd0, sclk_a}, 32'd0);
      end
      if (load_a === 1'b0) ld_low++;
      if (busy_a === 1'b1) busy_c++;
      if (done_a === 1'b1) dones++;
      if (sclk_a === 1'b1 && prev === 1'b0) begin
        rises++;
        bits = {bits[30:0], sdata_a};
      end
      prev = sclk_a;
    end
    rst = 1'b0;
  endtask

  logic [31:0] bits;
  logic [31:0] bits1, bits2;
  logic [15:0] bits_b;
  int          ld_low, rises, busy_c, dones, gap_hi, frame_idx, hi_cnt, hi_run, max_run;
  logic        prev, prev_load;

  initial begin
    rst = 1'b1; wr_a = 1'b0; data_a = '0; bcast_a = 1'b0;
    wr_b = 1'b0; data_b = '0; bcast_b = 1'b0;

    // Reset held three cycles, checked while asserted
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy_a}, 32'd1);
    chk("rst_load", {31'd0, load_a}, 32'd1);
    chk("rst_sclk", {31'd0, sclk_a}, 32'd0);
    chk("rst_data", {31'd0, sdata_a}, 32'd0);
    chk("rst_done", {31'd0, done_a}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_busy", {31'd0, busy_a}, 32'd0);

    // Plain frame
    frame_a(32'hA55A_0F01, 1'b0, 140, -1, bits, ld_low, rises, busy_c, dones);
    chk("f1_bits", bits, 32'hA55A_0F01);
    chk("f1_load_low", ld_low, 32'd128);
    chk("f1_rises", rises, 32'd32);
    chk("f1_busy", busy_c, 32'd132);
    chk("f1_done", dones, 32'd1);

    // Broadcast: low word replicated into both devices
    frame_a(32'hFFFF_0C01, 1'b1, 140, -1, bits, ld_low, rises, busy_c, dones);
    chk("bc_bits", bits, 32'h0C01_0C01);
    chk("bc_rises", rises, 32'd32);
    chk("bc_done", dones, 32'd1);

    // Back-to-back: wr held high, data = C3A5_0000 | k presented at negedge k.
    // Accepts land on the edges after negedge 0 and negedge 132.
    bits1 = '0; bits2 = '0; frame_idx = 0; gap_hi = 0; dones = 0;
    prev = 1'b0; prev_load = 1'b1;
    wr_a = 1'b1; bcast_a = 1'b0; data_a = 32'hC3A5_0000;
    for (int k = 1; k <= 270; k++) begin
      @(negedge clk);
      data_a = 32'hC3A5_0000 | 32'(k);
      wr_a = (k <= 140) ? 1'b1 : 1'b0;
      if (load_a === 1'b0 && prev_load === 1'b1) frame_idx++;
      if (frame_idx == 1 && load_a === 1'b1) gap_hi++;
      if (done_a === 1'b1) dones++;
      if (sclk_a === 1'b1 && prev === 1'b0) begin
        if (frame_idx == 1) bits1 = {bits1[30:0], sdata_a};
        else bits2 = {bits2[30:0], sdata_a};
      end
      prev = sclk_a;
      prev_load = load_a;
    end
    chk("b2b_frames", frame_idx, 32'd2);
    chk("b2b_bits1", bits1, 32'hC3A5_0000);
    chk("b2b_bits2", bits2, 32'hC3A5_0084);
    chk("b2b_gap", gap_hi, 32'd4);
    chk("b2b_dones", dones, 32'd2);

    // Reset pulsed mid-frame: aborted, no done, then a clean frame follows
    frame_a(32'h1234_5678, 1'b0, 140, 49, bits, ld_low, rises, busy_c, dones);
    chk("abort_done", dones, 32'd0);
    chk("abort_load_low", ld_low, 32'd50);
    frame_a(32'h8001_7FFE, 1'b0, 140, -1, bits, ld_low, rises, busy_c, dones);
    chk("post_bits", bits, 32'h8001_7FFE);
    chk("post_load_low", ld_low, 32'd128);
    chk("post_done", dones, 32'd1);

    // Single-device, CLK_DIV=2 corner
    wr_b = 1'b1; data_b = 16'hB38E; bcast_b = 1'b0;
    bits_b = '0; ld_low = 0; rises = 0; busy_c = 1; dones = 0;
    hi_cnt = 0; hi_run = 0; max_run = 0; prev = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      wr_b = 1'b0; data_b = 16'h0000;
      if (load_b === 1'b0) ld_low++;
      if (busy_b === 1'b1) busy_c++;
      if (done_b === 1'b1) dones++;
      if (sclk_b === 1'b1) begin
        hi_cnt++;
        hi_run++;
        if (hi_run > max_run) max_run = hi_run;
      end else begin
        hi_run = 0;
      end
      if (sclk_b === 1'b1 && prev === 1'b0) begin
        rises++;
        bits_b = {bits_b[14:0], sdata_b};
      end
      prev = sclk_b;
    end
    chk("b_bits", {16'd0, bits_b}, 32'h0000_B38E);
    chk("b_load_low", ld_low, 32'd32);
    chk("b_rises", rises, 32'd16);
    chk("b_sclk_high", hi_cnt, 32'd16);
    chk("b_sclk_run", max_run, 32'd1);
    chk("b_busy", busy_c, 32'd35);
    chk("b_done", dones, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
